// File: rtl/wavegen_pkg.sv
// Shared types and constants for the waveform generator DAC path.
package wavegen_pkg;

  localparam int unsigned SAMPLE_W = 10;
  localparam int unsigned FRAME_W  = 16;

  // Positions of the MCP49x1 configuration bits inside the command word.
  localparam int unsigned CFG_AB_BIT   = 15;
  localparam int unsigned CFG_BUF_BIT  = 14;
  localparam int unsigned CFG_GA_BIT   = 13;
  localparam int unsigned CFG_SHDN_BIT = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CS_HIGH = 2'd2,
    LATCH   = 2'd3
  } dac_tx_state_t;

endpackage

// File: rtl/tick_gen.sv
// Divider emitting a one-cycle tick every DIV clocks, with synchronous clear.
module tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // Count 0..DIV-1, restarting from zero on clear or terminal count.
  always_ff @(posedge clk_i) begin
    if (clr_i || cnt_q == TERM) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick_o = (cnt_q == TERM) && !clr_i;

endmodule

// File: rtl/dac_spi_tx.sv
// Frames 10-bit samples as MCP49x1 command words and shifts them out on
// a mode-0 SPI link, followed by an LDAC_n strobe per sample.
module dac_spi_tx
  import wavegen_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [3:0]  CFG_BITS = 4'b0111
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_ready,
  output logic                dac_cs_n,
  output logic                dac_sclk,
  output logic                dac_mosi,
  output logic                dac_ldac_n,
  output logic                busy
);

  dac_tx_state_t state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic cs_n_q, cs_n_d;
  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic ldac_n_q, ldac_n_d;
  logic busy_q, busy_d;
  logic tick;
  logic div_clr;

  // Divider held at zero while idle so the first SHIFT cycle starts a fresh half-period.
  assign div_clr = reset || (state_q == IDLE);

  tick_gen #(.DIV(CLK_DIV)) u_tick (
    .clk_i  (clk),
    .clr_i  (div_clr),
    .tick_o (tick)
  );

  assign sample_ready = (state_q == IDLE) && !reset;
  assign dac_cs_n     = cs_n_q;
  assign dac_sclk     = sclk_q;
  assign dac_mosi     = mosi_q;
  assign dac_ldac_n   = ldac_n_q;
  assign busy         = busy_q;

  // State and registered SPI outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_idx_q <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ldac_n_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ldac_n_q  <= ldac_n_d;
      busy_q    <= busy_d;
    end
  end

  // Next state: SCLK level doubles as the half-bit phase; MOSI moves with SCLK falling.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ldac_n_d  = ldac_n_q;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: begin
        if (sample_valid && sample_ready) begin
          state_d   = SHIFT;
          frame_d   = {CFG_BITS, sample_data, 2'b00};
          bit_idx_d = 4'd15;
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          mosi_d    = frame_d[FRAME_W-1];
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_idx_q == 4'd0) begin
              state_d = CS_HIGH;
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
            end else begin
              bit_idx_d = bit_idx_q - 4'd1;
              frame_d   = {frame_q[FRAME_W-2:0], 1'b0};
              mosi_d    = frame_d[FRAME_W-1];
            end
          end
        end
      end
      CS_HIGH: begin
        if (tick) begin
          state_d  = LATCH;
          ldac_n_d = 1'b0;
        end
      end
      LATCH: begin
        if (tick) begin
          state_d  = IDLE;
          ldac_n_d = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench: instance 0 uses default parameters, instance 1 uses
// CLK_DIV=1 with all configuration bits set.
module tb_dac_spi_tx;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] vld = 2'b00;
  logic [9:0] dat [2];
  logic [1:0] rdy, cs_n, sclk, mosi, ldac_n, busy;

  always #5 clk = ~clk;

  dac_spi_tx u_dut0 (
    .clk(clk), .reset(rst[0]), .sample_valid(vld[0]), .sample_data(dat[0]),
    .sample_ready(rdy[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]),
    .dac_mosi(mosi[0]), .dac_ldac_n(ldac_n[0]), .busy(busy[0])
  );

  dac_spi_tx #(.CLK_DIV(1), .CFG_BITS(4'b1111)) u_dut1 (
    .clk(clk), .reset(rst[1]), .sample_valid(vld[1]), .sample_data(dat[1]),
    .sample_ready(rdy[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]),
    .dac_mosi(mosi[1]), .dac_ldac_n(ldac_n[1]), .busy(busy[1])
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Link monitor: reconstructs words from MOSI at SCLK rising and measures timing.
  int cyc = 0;
  logic [1:0] p_cs = 2'b11, p_sclk = 2'b00, p_ld = 2'b11;
  int sh [2], nb [2], csl [2], ldl [2], rise [2];
  int m_word [2][64], m_bits [2][64], m_csl [2][64], m_fall [2][64];
  int m_gap [2][64], m_ldl [2][64], m_len [2][64];
  int m_nf [2] = '{0, 0}, m_nfall [2] = '{0, 0}, m_nl [2] = '{0, 0};

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (p_cs[i] && !cs_n[i]) begin
        sh[i] = 0; nb[i] = 0; csl[i] = 0;
        m_fall[i][m_nfall[i] & 63] = cyc;
        m_nfall[i]++;
      end
      if (!cs_n[i]) begin
        csl[i]++;
        if (!p_sclk[i] && sclk[i]) begin
          sh[i] = (sh[i] << 1) | int'(mosi[i]);
          nb[i]++;
        end
      end
      if (!p_cs[i] && cs_n[i]) begin
        m_word[i][m_nf[i] & 63] = sh[i];
        m_bits[i][m_nf[i] & 63] = nb[i];
        m_csl[i][m_nf[i] & 63]  = csl[i];
        rise[i] = cyc;
        m_nf[i]++;
      end
      if (p_ld[i] && !ldac_n[i]) begin
        m_gap[i][m_nl[i] & 63] = cyc - rise[i];
        ldl[i] = 0;
      end
      if (!ldac_n[i]) ldl[i]++;
      if (!p_ld[i] && ldac_n[i]) begin
        m_ldl[i][m_nl[i] & 63] = ldl[i];
        m_len[i][m_nl[i] & 63] = cyc - m_fall[i][(m_nfall[i] - 1) & 63];
        m_nl[i]++;
      end
    end
    p_cs = cs_n; p_sclk = sclk; p_ld = ldac_n;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [9:0] d);
    int t = 0;
    while (!rdy[i] && t < 300) begin tick(); t++; end
    chk("ready_wait", int'(rdy[i]), 1);
    vld[i] = 1'b1; dat[i] = d;
    tick();
    vld[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int target);
    int t = 0;
    while (m_nl[i] < target && t < 3000) begin tick(); t++; end
    chk("frame_done", int'(m_nl[i] >= target), 1);
  endtask

  // Reference model: command word = {cfg, sample, 2'b00} as plain arithmetic.
  function automatic int model_word(input int cfg, input int d);
    return cfg * 4096 + d * 4;
  endfunction

  typedef struct {
    logic [9:0]  d;
    logic [15:0] w;
  } vec_t;

  vec_t tbl [5];
  int   exp_q [$];

  initial begin
    int base, nf0, t, d0, dk;
    dat[0] = '0; dat[1] = '0;
    tbl[0] = '{10'h155, 16'h7554};
    tbl[1] = '{10'h3FF, 16'h7FFC};
    tbl[2] = '{10'h000, 16'h7000};
    tbl[3] = '{10'h200, 16'h7800};
    tbl[4] = '{10'h001, 16'h7004};

    // Reset state.
    repeat (3) tick();
    chk("rst_cs_n", int'(cs_n[0]), 1);
    chk("rst_sclk", int'(sclk[0]), 0);
    chk("rst_mosi", int'(mosi[0]), 0);
    chk("rst_ldac_n", int'(ldac_n[0]), 1);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_ready", int'(rdy[0]), 0);
    chk("rst_cs_n_b", int'(cs_n[1]), 1);
    rst = 2'b00;
    #1;
    chk("ready_after_rst", int'(rdy[0]), 1);

    // Table of single frames at default parameters.
    for (int k = 0; k < 5; k++) begin
      base = m_nl[0];
      send(0, tbl[k].d);
      wait_done(0, base + 1);
      chk("tbl_word", m_word[0][(m_nf[0] - 1) & 63], int'(tbl[k].w));
      chk("tbl_bits", m_bits[0][(m_nf[0] - 1) & 63], 16);
      chk("tbl_cs_low", m_csl[0][(m_nf[0] - 1) & 63], 64);
      chk("tbl_ldac_gap", m_gap[0][base & 63], 2);
      chk("tbl_ldac_len", m_ldl[0][base & 63], 2);
      chk("tbl_frame_len", m_len[0][base & 63], 68);
    end

    // Back-to-back with valid held high.
    tick();
    base = m_nl[0]; nf0 = m_nfall[0];
    vld[0] = 1'b1; dat[0] = 10'h3FF;
    tick();
    t = 0;
    while (m_nf[0] < base + 1 && t < 300) begin tick(); t++; end
    dat[0] = 10'h000;
    t = 0;
    while (m_nfall[0] < nf0 + 2 && t < 300) begin tick(); t++; end
    vld[0] = 1'b0;
    wait_done(0, base + 2);
    chk("b2b_word0", m_word[0][(m_nf[0] - 2) & 63], 16'h7FFC);
    chk("b2b_word1", m_word[0][(m_nf[0] - 1) & 63], 16'h7000);
    chk("b2b_period", m_fall[0][(nf0 + 1) & 63] - m_fall[0][nf0 & 63], 69);

    // Data toggled every cycle; second acceptance lands 69 cycles after the first.
    tick();
    base = m_nl[0];
    d0 = 10'h155;
    dk = 0;
    vld[0] = 1'b1; dat[0] = 10'(d0);
    for (int k = 1; k <= 69; k++) begin
      tick();
      dk = int'($urandom_range(0, 1023));
      dat[0] = 10'(dk);
    end
    tick();
    vld[0] = 1'b0;
    wait_done(0, base + 2);
    chk("toggle_word0", m_word[0][(m_nf[0] - 2) & 63], model_word(7, d0));
    chk("toggle_word1", m_word[0][(m_nf[0] - 1) & 63], model_word(7, dk));

    // Reset during bit index 7 aborts the frame and suppresses LDAC.
    tick();
    base = m_nl[0];
    send(0, 10'h155);
    t = 0;
    while (!(nb[0] == 8 && sclk[0] == 1'b0) && t < 300) begin tick(); t++; end
    rst[0] = 1'b1;
    tick();
    chk("abort_cs_n", int'(cs_n[0]), 1);
    chk("abort_sclk", int'(sclk[0]), 0);
    chk("abort_ldac_n", int'(ldac_n[0]), 1);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_ready_in_rst", int'(rdy[0]), 0);
    rst[0] = 1'b0;
    #1;
    chk("abort_ready_after", int'(rdy[0]), 1);
    chk("abort_partial", m_word[0][(m_nf[0] - 1) & 63], 16'h0075);
    repeat (80) tick();
    chk("abort_no_ldac", m_nl[0], base);

    // Valid and reset on the same edge.
    nf0 = m_nfall[0];
    rst[0] = 1'b1; vld[0] = 1'b1; dat[0] = 10'h123;
    tick();
    chk("vr_busy", int'(busy[0]), 0);
    chk("vr_cs_n", int'(cs_n[0]), 1);
    rst[0] = 1'b0; vld[0] = 1'b0;
    repeat (3) tick();
    chk("vr_busy_after", int'(busy[0]), 0);
    chk("vr_no_frame", m_nfall[0], nf0);

    // CLK_DIV=1, all configuration bits set.
    base = m_nl[1];
    send(1, 10'h2A5);
    wait_done(1, base + 1);
    chk("div1_word", m_word[1][(m_nf[1] - 1) & 63], 16'hFA94);
    chk("div1_bits", m_bits[1][(m_nf[1] - 1) & 63], 16);
    chk("div1_cs_low", m_csl[1][(m_nf[1] - 1) & 63], 32);
    chk("div1_ldac_gap", m_gap[1][base & 63], 1);
    chk("div1_frame_len", m_len[1][base & 63], 34);

    // Randomized samples with random idle gaps against the reference model.
    base = m_nf[0];
    t = m_nl[0];
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 5)) tick();
      dk = int'($urandom_range(0, 1023));
      exp_q.push_back(model_word(7, dk));
      send(0, 10'(dk));
    end
    wait_done(0, t + 20);
    for (int k = 0; k < 20; k++) begin
      chk("rand_word", m_word[0][(base + k) & 63], exp_q[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
